// File: rtl/mips_defs.sv
// Opcode/funct encodings and reset values shared by the MIPS decode stage.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Every store (sb/sh/sw/...) lives in the 101xxx opcode group and reads rt.
  function automatic logic is_store_op(input logic [5:0] op);
    return op[5:3] == 3'b101;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage signal bundle: fetch/hazard/writeback inputs and decode outputs.
interface id_stage_if;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        ex_wr_en;
  logic [4:0]  ex_wr_addr;
  logic        ex_is_load;
  logic        mem_wr_en;
  logic [4:0]  mem_wr_addr;
  logic        mem_is_load;
  logic [31:0] mem_wr_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] nPCAlt;
  logic        nPCSel;
  logic        Stall;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm_ext;
  logic [31:0] link_pc;

  modport master (
    output if_pc, if_instr, ex_wr_en, ex_wr_addr, ex_is_load,
           mem_wr_en, mem_wr_addr, mem_is_load, mem_wr_data,
           wb_we, wb_addr, wb_data,
    input  nPCAlt, nPCSel, Stall, id_pc, id_instr, id_valid,
           rs_data, rt_data, imm_ext, link_pc
  );

  modport slave (
    input  if_pc, if_instr, ex_wr_en, ex_wr_addr, ex_is_load,
           mem_wr_en, mem_wr_addr, mem_is_load, mem_wr_data,
           wb_we, wb_addr, wb_data,
    output nPCAlt, nPCSel, Stall, id_pc, id_instr, id_valid,
           rs_data, rt_data, imm_ext, link_pc
  );
endinterface

// File: rtl/grf.sv
// 32x32 general register file: two combinational read ports, one write port,
// $0 hard-wired to zero, same-cycle write-through on reads.
module grf (
  input  logic            Clk,
  input  logic            Rst,
  input  logic [1:0][4:0] raddr_i,
  output logic [1:0][31:0] rdata_o,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [31:0]     wdata_i
);

  logic [31:0] regs_q [32];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != 5'd0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    assign rdata_o[gi] = (raddr_i[gi] == 5'd0)                ? 32'd0   :
                         (we_i && waddr_i == raddr_i[gi])     ? wdata_i :
                                                                regs_q[raddr_i[gi]];
  end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: IF/ID register, register file, branch/jump redirect with
// delay-slot semantics, load-use and branch-operand hazard stalls.
module id_stage import mips_defs::*; #(
  parameter logic [31:0] RESET_PC  = mips_defs::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_defs::NOP_INSTR
) (
  input logic        Clk,
  input logic        Rst,
  id_stage_if.slave  bus
);

  logic [31:0] pc_q, instr_q;
  logic        valid_q;
  logic        stall;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= bus.if_pc;
      instr_q <= bus.if_instr;
      valid_q <= 1'b1;
    end
  end

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  assign op    = instr_q[31:26];
  assign rs    = instr_q[25:21];
  assign rt    = instr_q[20:16];
  assign funct = instr_q[5:0];

  logic is_beq, is_bne, is_j, is_jal, is_jr, uses_rs, uses_rt;
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
  assign uses_rs = !(is_j || is_jal);
  assign uses_rt = (op == OP_RTYPE) || is_beq || is_bne || is_store_op(op);

  logic [1:0][31:0] rdata;
  grf u_grf (
    .Clk     (Clk),
    .Rst     (Rst),
    .raddr_i ({rt, rs}),
    .rdata_o (rdata),
    .we_i    (bus.wb_we),
    .waddr_i (bus.wb_addr),
    .wdata_i (bus.wb_data)
  );

  // Compare operands: a non-load result sitting in MEM beats the regfile value.
  logic [31:0] cmp_rs, cmp_rt;
  logic        fwd_rs, fwd_rt;
  assign fwd_rs = bus.mem_wr_en && !bus.mem_is_load && rs != 5'd0 && bus.mem_wr_addr == rs;
  assign fwd_rt = bus.mem_wr_en && !bus.mem_is_load && rt != 5'd0 && bus.mem_wr_addr == rt;
  assign cmp_rs = fwd_rs ? bus.mem_wr_data : rdata[0];
  assign cmp_rt = fwd_rt ? bus.mem_wr_data : rdata[1];

  logic load_use, br_haz_rs, br_haz_rt, br_stall;
  assign load_use = bus.ex_is_load && bus.ex_wr_en && bus.ex_wr_addr != 5'd0 &&
                    ((uses_rs && bus.ex_wr_addr == rs) || (uses_rt && bus.ex_wr_addr == rt));
  assign br_haz_rs = rs != 5'd0 &&
                     ((bus.ex_wr_en && bus.ex_wr_addr == rs) ||
                      (bus.mem_wr_en && bus.mem_is_load && bus.mem_wr_addr == rs));
  assign br_haz_rt = rt != 5'd0 &&
                     ((bus.ex_wr_en && bus.ex_wr_addr == rt) ||
                      (bus.mem_wr_en && bus.mem_is_load && bus.mem_wr_addr == rt));
  assign br_stall  = ((is_beq || is_bne) && (br_haz_rs || br_haz_rt)) || (is_jr && br_haz_rs);
  assign stall     = load_use || br_stall;

  logic [31:0] imm_ext, pc_plus4, br_target, j_target;
  assign imm_ext   = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign j_target  = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  logic        sel;
  logic [31:0] alt;
  always_comb begin
    sel = 1'b0;
    alt = 32'd0;
    if (valid_q && !stall) begin
      if ((is_beq && cmp_rs == cmp_rt) || (is_bne && cmp_rs != cmp_rt)) begin
        sel = 1'b1;
        alt = br_target;
      end else if (is_j || is_jal) begin
        sel = 1'b1;
        alt = j_target;
      end else if (is_jr) begin
        sel = 1'b1;
        alt = cmp_rs;
      end
    end
  end

  assign bus.nPCSel   = sel;
  assign bus.nPCAlt   = alt;
  assign bus.Stall    = stall;
  assign bus.id_pc    = pc_q;
  assign bus.id_instr = instr_q;
  assign bus.id_valid = valid_q && !stall;
  assign bus.rs_data  = rdata[0];
  assign bus.rt_data  = rdata[1];
  assign bus.imm_ext  = imm_ext;
  assign bus.link_pc  = pc_q + 32'd8;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against a behavioural decode-stage model.
module tb_id_stage;
  import mips_defs::*;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  id_stage_if ifc ();
  id_stage dut (.Clk(Clk), .Rst(Rst), .bus(ifc.slave));

  int checks = 0;
  int errors = 0;

  // Model state: architectural registers and IF/ID contents.
  logic [31:0] m_regs [32];
  logic [31:0] m_pc, m_instr;
  logic        m_valid;

  // Predictions for the current cycle.
  logic        e_stall, e_sel, e_valid;
  logic [31:0] e_alt, e_rs, e_rt, e_imm, e_link;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pc    = 32'h0000_3000;
    m_instr = 32'd0;
    m_valid = 1'b0;
  endtask

  function automatic logic [31:0] reg_val(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ifc.wb_we && ifc.wb_addr == a) return ifc.wb_data;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] cmp_val(input logic [4:0] a);
    if (a != 5'd0 && ifc.mem_wr_en && !ifc.mem_is_load && ifc.mem_wr_addr == a)
      return ifc.mem_wr_data;
    return reg_val(a);
  endfunction

  task automatic predict();
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic [4:0] used [$];
    logic [4:0] compared [$];
    logic       jr;
    int         offs;
    op = m_instr[31:26]; fn = m_instr[5:0];
    rs = m_instr[25:21]; rt = m_instr[20:16];
    jr = (op == 6'h00) && (fn == 6'h08);
    used.delete(); compared.delete();
    if (op != 6'h02 && op != 6'h03) used.push_back(rs);
    if (op == 6'h00 || op == 6'h04 || op == 6'h05 || op[5:3] == 3'b101) used.push_back(rt);
    if (op == 6'h04 || op == 6'h05) begin compared.push_back(rs); compared.push_back(rt); end
    if (jr) compared.push_back(rs);
    e_stall = 1'b0;
    foreach (used[k])
      if (ifc.ex_is_load && ifc.ex_wr_en && used[k] != 0 && used[k] == ifc.ex_wr_addr) e_stall = 1'b1;
    foreach (compared[k])
      if (compared[k] != 0 &&
          ((ifc.ex_wr_en && ifc.ex_wr_addr == compared[k]) ||
           (ifc.mem_wr_en && ifc.mem_is_load && ifc.mem_wr_addr == compared[k]))) e_stall = 1'b1;
    e_valid = m_valid && !e_stall;
    e_rs    = reg_val(rs);
    e_rt    = reg_val(rt);
    offs    = $signed(m_instr[15:0]);
    e_imm   = offs;
    e_link  = m_pc + 32'd8;
    e_sel   = 1'b0;
    e_alt   = 32'd0;
    if (m_valid && !e_stall) begin
      if ((op == 6'h04 && cmp_val(rs) == cmp_val(rt)) || (op == 6'h05 && cmp_val(rs) != cmp_val(rt))) begin
        e_sel = 1'b1; e_alt = m_pc + 32'd4 + 32'(offs * 4);
      end else if (op == 6'h02 || op == 6'h03) begin
        e_sel = 1'b1; e_alt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(m_instr[25:0]) * 4);
      end else if (jr) begin
        e_sel = 1'b1; e_alt = cmp_val(rs);
      end
    end
  endtask

  task automatic step_eval();
    #1;
    predict();
    chk("id_pc",    ifc.id_pc,    m_pc);
    chk("id_instr", ifc.id_instr, m_instr);
    chk("id_valid", 32'(ifc.id_valid), 32'(e_valid));
    chk("Stall",    32'(ifc.Stall),    32'(e_stall));
    chk("nPCSel",   32'(ifc.nPCSel),   32'(e_sel));
    chk("nPCAlt",   ifc.nPCAlt,   e_alt);
    chk("rs_data",  ifc.rs_data,  e_rs);
    chk("rt_data",  ifc.rt_data,  e_rt);
    chk("imm_ext",  ifc.imm_ext,  e_imm);
    chk("link_pc",  ifc.link_pc,  e_link);
  endtask

  task automatic step_clock();
    @(posedge Clk);
    if (Rst) begin
      if (!e_stall) begin m_pc = ifc.if_pc; m_instr = ifc.if_instr; m_valid = 1'b1; end
      if (ifc.wb_we && ifc.wb_addr != 5'd0) m_regs[ifc.wb_addr] = ifc.wb_data;
    end
    @(negedge Clk);
  endtask

  task automatic idle();
    ifc.ex_wr_en = 0; ifc.ex_wr_addr = 0; ifc.ex_is_load = 0;
    ifc.mem_wr_en = 0; ifc.mem_wr_addr = 0; ifc.mem_is_load = 0; ifc.mem_wr_data = 0;
    ifc.wb_we = 0; ifc.wb_addr = 0; ifc.wb_data = 0;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    ifc.if_pc = pc; ifc.if_instr = instr;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    ifc.wb_we = 1; ifc.wb_addr = a; ifc.wb_data = d;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 8))
      0:       return rtype(rs, rt, 5'($urandom_range(0, 31)), 6'h20);
      1:       return rtype(rs, 5'd0, 5'd0, FN_JR);
      2:       return {OP_BEQ, rs, rt, imm};
      3:       return {OP_BNE, rs, rt, imm};
      4:       return {OP_J, 26'($urandom)};
      5:       return {OP_JAL, 26'($urandom)};
      6:       return {OP_LW, rs, rt, imm};
      7:       return {OP_SW, rs, rt, imm};
      default: return {6'h08, rs, rt, imm};
    endcase
  endfunction

  localparam logic [31:0] ADD_9_8_1 = 32'h0101_4820;

  initial begin
    model_reset();
    idle();
    fetch(32'h0, 32'h0);

    // Reset state
    @(negedge Clk);
    step_eval();
    chk("rst_id_pc", ifc.id_pc, 32'h0000_3000);
    step_clock();
    Rst = 1'b1;

    // Write to $0 is discarded
    fetch(32'h3000, rtype(5'd0, 5'd0, 5'd1, 6'h20));
    wb(5'd0, 32'hFFFF_FFFF);
    step_eval(); step_clock();
    idle(); fetch(32'h3004, rtype(5'd5, 5'd0, 5'd2, 6'h20));
    step_eval(); chk("r0_read", ifc.rs_data, 32'd0); step_clock();

    // Write-through bypass
    wb(5'd5, 32'h1234); fetch(32'h3008, ADD_9_8_1);
    step_eval(); chk("bypass_rs", ifc.rs_data, 32'h1234); step_clock();

    // Load-use: one bubble, IF/ID held
    idle(); ifc.ex_wr_en = 1; ifc.ex_wr_addr = 5'd8; ifc.ex_is_load = 1;
    fetch(32'h300C, 32'h0);
    step_eval(); chk("lu_stall", 32'(ifc.Stall), 32'd1); chk("lu_bubble", 32'(ifc.id_valid), 32'd0); step_clock();
    idle();
    step_eval(); chk("lu_release", 32'(ifc.Stall), 32'd0); chk("lu_hold", ifc.id_instr, ADD_9_8_1); step_clock();

    // beq taken / bne not taken with $2=$3=7
    wb(5'd2, 32'd7); fetch(32'h3010, {OP_BEQ, 5'd2, 5'd3, 16'd4});
    step_eval(); step_clock();
    wb(5'd3, 32'd7); fetch(32'h3014, 32'h0);
    step_eval(); chk("beq_sel", 32'(ifc.nPCSel), 32'd1); chk("beq_alt", ifc.nPCAlt, 32'h3024); step_clock();
    idle(); fetch(32'h3010, {OP_BNE, 5'd2, 5'd3, 16'd4});
    step_eval(); step_clock();
    fetch(32'h3014, 32'h0);
    step_eval(); chk("bne_sel", 32'(ifc.nPCSel), 32'd0); step_clock();

    // jr $31 forwarded from MEM, then stalled behind a load
    fetch(32'h3020, rtype(5'd31, 5'd0, 5'd0, FN_JR));
    step_eval(); step_clock();
    ifc.mem_wr_en = 1; ifc.mem_wr_addr = 5'd31; ifc.mem_wr_data = 32'h3400;
    step_eval(); chk("jr_alt", ifc.nPCAlt, 32'h3400); chk("jr_nostall", 32'(ifc.Stall), 32'd0); step_clock();
    ifc.mem_is_load = 1;
    step_eval(); chk("jr_ld_stall", 32'(ifc.Stall), 32'd1); step_clock();

    // jal target and link, then link wrap
    idle(); fetch(32'hF000_0000, {OP_JAL, 26'h0000100});
    step_eval(); step_clock();
    fetch(32'hFFFF_FFFC, 32'h0);
    step_eval(); chk("jal_alt", ifc.nPCAlt, 32'hF000_0400); chk("jal_link", ifc.link_pc, 32'hF000_0008); step_clock();
    fetch(32'h0, 32'h0);
    step_eval(); chk("link_wrap", ifc.link_pc, 32'h0000_0004); step_clock();

    // Reset asserted mid-stall
    fetch(32'h3100, ADD_9_8_1);
    step_eval(); step_clock();
    ifc.ex_wr_en = 1; ifc.ex_wr_addr = 5'd8; ifc.ex_is_load = 1;
    step_eval(); chk("pre_rst_stall", 32'(ifc.Stall), 32'd1);
    #1 Rst = 1'b0;
    #1;
    chk("rst_stall", 32'(ifc.Stall), 32'd0);
    chk("rst_valid", 32'(ifc.id_valid), 32'd0);
    chk("rst_pc", ifc.id_pc, 32'h0000_3000);
    model_reset();
    @(posedge Clk); @(negedge Clk);
    idle();
    step_eval(); chk("rst_reg9", ifc.rs_data, 32'd0);
    Rst = 1'b1;
    step_clock();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ifc.if_pc       = $urandom_range(0, 3) == 0 ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4) : $urandom;
      ifc.if_instr    = rand_instr();
      ifc.ex_wr_en    = 1'($urandom);
      ifc.ex_wr_addr  = 5'($urandom_range(0, 7));
      ifc.ex_is_load  = ($urandom_range(0, 3) == 0);
      ifc.mem_wr_en   = 1'($urandom);
      ifc.mem_wr_addr = 5'($urandom_range(0, 7));
      ifc.mem_is_load = ($urandom_range(0, 2) == 0);
      ifc.mem_wr_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      ifc.wb_we       = 1'($urandom);
      ifc.wb_addr     = 5'($urandom_range(0, 7));
      ifc.wb_data     = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      step_eval();
      step_clock();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode stage of the 5-stage MIPS pipeline, directly downstream of instruction fetch.
- Contains the IF/ID pipeline register, the 32x32 register file, branch/jump resolution and load-use/branch hazard detection.
- Drives the redirect (nPCAlt/nPCSel) and Stall back to fetch, and feeds decoded operands to the ID/EX register.
- Branches use MIPS delay-slot semantics: the slot instruction in fetch is never squashed.

Parameters:
RESET_PC, 32'h0000_3000, PC value held in the IF/ID register after reset
NOP_INSTR, 32'h0000_0000, instruction value held while the IF/ID register is empty

Ports:
Clk  in  1  clock, rising edge
Rst  in  1  asynchronous, active-low reset
if_pc  in  32  PC from fetch
if_instr  in  32  instruction from fetch
ex_wr_en  in  1  instruction in EX will write a register
ex_wr_addr  in  5  destination register of the EX instruction
ex_is_load  in  1  EX instruction is a load
mem_wr_en  in  1  instruction in MEM will write a register
mem_wr_addr  in  5  destination register of the MEM instruction
mem_is_load  in  1  MEM instruction is a load
mem_wr_data  in  32  ALU result in MEM (forwarding source)
wb_we  in  1  writeback enable
wb_addr  in  5  writeback register
wb_data  in  32  writeback data
nPCAlt  out  32  redirect target to fetch
nPCSel  out  1  take nPCAlt
Stall  out  1  hold fetch PC and the IF/ID register
id_pc, id_instr  out  32 each  contents of the IF/ID register
id_valid  out  1  the ID/EX register must latch a real instruction (0 = bubble)
rs_data, rt_data  out  32 each  register operands
imm_ext  out  32  sign-extended imm16
link_pc  out  32  id_pc + 8, for jal

Behaviour:
- Reset (Rst=0, asynchronous) and after reset:
  - IF/ID register: id_pc=RESET_PC, id_instr=NOP_INSTR, internal valid=0.
  - All 32 registers are 0.
  - nPCSel=0, Stall=0, id_valid=0.
- IF/ID register on each rising edge:
  - Stall=0: latch if_pc, if_instr, valid=1.
  - Stall=1: hold its contents.
- Decode outputs are combinational from the IF/ID register (zero added latency).
- Register file:
  - Writes on the rising edge when wb_we=1 and wb_addr!=0.
  - $0 always reads as 0.
  - A read of wb_addr while wb_we=1 returns wb_data in the same cycle (write-through bypass).
- Source usage:
  - rs is used by all instructions except j and jal.
  - rt is used by R-type, beq, bne and stores.
- Load-use stall: Stall=1 when all of the following hold:
  - ex_is_load=1, ex_wr_en=1 and ex_wr_addr!=0;
  - ex_wr_addr equals a used source register.
- Branch/jr stall: for beq, bne and jr, Stall=1 when a compared source register (nonzero) matches either:
  - ex_wr_addr with ex_wr_en=1; or
  - mem_wr_addr with mem_wr_en=1 and mem_is_load=1.
- Branch forwarding: when the MEM instruction is a non-load, mem_wr_en=1 and mem_wr_addr matches a nonzero compared source register, the compare uses mem_wr_data.
  - This forward takes priority over the regfile/bypass value.
- While Stall=1: id_valid=0 (bubble into EX) and nPCSel=0.
- Otherwise: id_valid = internal valid.
- Redirect is asserted only when internal valid=1 and Stall=0:
  - beq (op 000100) taken if equal; bne (op 000101) taken if not equal. Target = id_pc + 4 + (sext(imm16) << 2).
  - j (op 000010) and jal (op 000011): target = {(id_pc+4)[31:28], instr_index, 2'b00}.
  - jr (op 0, funct 001000): target = forwarded rs value.
  - In all taken cases nPCSel=1. Not-taken branch or no branch: nPCSel=0, nPCAlt=0.
- All PC arithmetic is modulo 2^32 (wrap-around allowed).
- Reset asserted mid-stall clears the stall immediately; the pipeline restarts empty.

Decomposition:
- Shared package mips_defs: opcode/funct constants (OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR, OP_LW), RESET_PC, NOP_INSTR.
- One sub-module, grf: the 32x32 register file with async reset, two read ports, one write port and write-through bypass.
- Hazard, forwarding and redirect logic stays in id_stage.

Test Plan:
- Reset, then hold Rst=0 mid-run -> id_pc=0x3000, id_valid=0, rs_data=0; a read of $0 after writing 0xFFFF_FFFF to $0 returns 0.
- wb_we=1, wb_addr=5, wb_data=0x1234 in the same cycle that ID reads $5 -> rs_data=0x1234 that cycle.
- EX holds lw $8; ID holds add $9,$8,$1 -> exactly one cycle of Stall=1 and id_valid=0; the next cycle Stall=0, id_valid=1, and the IF/ID contents are unchanged.
- $2=$3=7; id_pc=0x3010 with beq $2,$3,+4 -> nPCSel=1, nPCAlt=0x3024. Same test with bne -> nPCSel=0.
- jr $31 while MEM holds a non-load writing $31=0x3400 -> nPCAlt=0x3400 with no stall. Same test with a load in MEM -> one stall cycle.
- jal with id_pc=0xF000_0000 and instr_index=0x0000100 -> nPCAlt=0xF000_0400, link_pc=0xF000_0008. id_pc=0xFFFF_FFFC -> link_pc=0x0000_0004 (wrap).
